// File: rtl/uart_instr_loader.sv
// UART (8N1, LSB first) program loader: pairs received bytes into 16-bit words,
// writes them to instruction memory from START_ADDR, and flags done after the line idles.
module uart_instr_loader #(
  parameter int CLKS_PER_BIT      = 868,
  parameter int ADDR_W            = 8,
  parameter int START_ADDR        = 1,
  parameter int IDLE_TIMEOUT_BITS = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  output logic              o_instr_transmit_done,
  output logic [ADDR_W-1:0] o_max_addr,
  output logic              o_frame_err,
  output logic              o_overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int TMO   = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMR_W = $clog2(TMO + 1);
  localparam logic [CNT_W-1:0]  HALF_CNT   = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0]  TMO_LAST   = TMR_W'(TMO - 1);
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  logic              sync1_q, sync2_q, rx_s;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_vld_q, byte_vld_d;
  logic [7:0]        hi_q, hi_d;
  logic              have_hi_q, have_hi_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wrote_q, wrote_d;
  logic              full_q, full_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] max_addr_q, max_addr_d;
  logic              frame_err_q, frame_err_d;
  logic              overflow_q, overflow_d;

  assign rx_s = sync2_q;

  // Two-flop synchronizer for the asynchronous RX line, idling high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: RX framing, byte pairing, memory write and idle timer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_vld_d  = 1'b0;
    hi_d        = hi_q;
    have_hi_d   = have_hi_q;
    ptr_d       = ptr_q;
    wrote_d     = wrote_q;
    full_d      = full_q;
    tmr_d       = tmr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    max_addr_d  = max_addr_q;
    frame_err_d = frame_err_q;
    overflow_d  = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (!done_q && !rx_s) begin
          state_d   = ST_START;
          cnt_d     = '0;
          bit_idx_d = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rx_s) begin
            byte_vld_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            have_hi_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // shift_q stays stable until the next DATA state, so it is the received byte here.
    if (byte_vld_q && !done_q) begin
      if (!have_hi_q) begin
        hi_d      = shift_q;
        have_hi_d = 1'b1;
      end else begin
        have_hi_d = 1'b0;
        if (!full_q) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = {hi_q, shift_q};
          max_addr_d  = ptr_q;
          wrote_d     = 1'b1;
          if (ptr_q == ADDR_LAST) begin
            full_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end else begin
          overflow_d = 1'b1;
        end
      end
    end else begin
      hi_d = hi_q;
    end

    if (done_q) begin
      tmr_d = tmr_q;
    end else if (state_q == ST_IDLE && !rx_s) begin
      tmr_d = '0;
    end else if (state_q == ST_IDLE && wrote_q) begin
      if (tmr_q == TMO_LAST) begin
        done_d    = 1'b1;
        have_hi_d = 1'b0;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end else begin
      tmr_d = tmr_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      byte_vld_q  <= 1'b0;
      hi_q        <= 8'd0;
      have_hi_q   <= 1'b0;
      ptr_q       <= ADDR_FIRST;
      wrote_q     <= 1'b0;
      full_q      <= 1'b0;
      tmr_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'd0;
      done_q      <= 1'b0;
      max_addr_q  <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_vld_q  <= byte_vld_d;
      hi_q        <= hi_d;
      have_hi_q   <= have_hi_d;
      ptr_q       <= ptr_d;
      wrote_q     <= wrote_d;
      full_q      <= full_d;
      tmr_q       <= tmr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      max_addr_q  <= max_addr_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_mem_we              = mem_we_q;
  assign o_mem_addr            = mem_addr_q;
  assign o_mem_wdata           = mem_wdata_q;
  assign o_instr_transmit_done = done_q;
  assign o_max_addr            = max_addr_q;
  assign o_frame_err           = frame_err_q;
  assign o_overflow            = overflow_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Scoreboard bench: expected writes are queued as pairs are sent and matched on every o_mem_we.
module tb_uart_instr_loader;
  localparam int CLKS    = 16;
  localparam int TMO_CYC = 20 * CLKS;
  // Stop-bit sample edge sits this many cycles before the end of the driven frame.
  localparam int LAG     = CLKS - CLKS / 2 - 4;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic rx2 = 1'b1;

  logic        we, done, ferr, ovf;
  logic [7:0]  addr, maxa;
  logic [15:0] wdata;
  logic        we2, done2, ferr2, ovf2;
  logic [1:0]  addr2, maxa2;
  logic [15:0] wdata2;

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];
  wr_t exp2_q[$];

  always #5 clk = ~clk;

  uart_instr_loader #(.CLKS_PER_BIT(CLKS), .ADDR_W(8), .START_ADDR(1), .IDLE_TIMEOUT_BITS(20)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx),
    .o_mem_we(we), .o_mem_addr(addr), .o_mem_wdata(wdata),
    .o_instr_transmit_done(done), .o_max_addr(maxa),
    .o_frame_err(ferr), .o_overflow(ovf)
  );

  uart_instr_loader #(.CLKS_PER_BIT(CLKS), .ADDR_W(2), .START_ADDR(1), .IDLE_TIMEOUT_BITS(20)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx2),
    .o_mem_we(we2), .o_mem_addr(addr2), .o_mem_wdata(wdata2),
    .o_instr_transmit_done(done2), .o_max_addr(maxa2),
    .o_frame_err(ferr2), .o_overflow(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard for the 8-bit-address loader.
  always @(negedge clk) begin
    if (!rst && we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", {31'd0, we}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, addr}, {24'd0, e.addr});
        check("wr_data", {16'd0, wdata}, {16'd0, e.data});
      end
    end
  end

  // Scoreboard for the 2-bit-address loader.
  always @(negedge clk) begin
    if (!rst && we2) begin
      if (exp2_q.size() == 0) begin
        check("spurious_we2", {31'd0, we2}, 32'd0);
      end else begin
        wr_t e;
        e = exp2_q.pop_front();
        check("wr2_addr", {30'd0, addr2}, {24'd0, e.addr});
        check("wr2_data", {16'd0, wdata2}, {16'd0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic which, input logic v);
    if (which) rx2 = v;
    else       rx  = v;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"},    {31'd0, we},    32'd0);
    check({tag, "_addr"},  {24'd0, addr},  32'd0);
    check({tag, "_wdata"}, {16'd0, wdata}, 32'd0);
    check({tag, "_done"},  {31'd0, done},  32'd0);
    check({tag, "_maxa"},  {24'd0, maxa},  32'd0);
    check({tag, "_ferr"},  {31'd0, ferr},  32'd0);
    check({tag, "_ovf"},   {31'd0, ovf},   32'd0);
    check({tag, "_ovf2"},  {31'd0, ovf2},  32'd0);
    check({tag, "_maxa2"}, {30'd0, maxa2}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    rx2 = 1'b1;
    tick();
    tick();
    exp_q.delete();
    exp2_q.delete();
    check_zero("rst");
    rst = 1'b0;
    repeat (2) tick();
  endtask

  // Frame bits: 0 start, 1..8 data LSB first, 9 stop. rst_at_bit >= 0 pulses reset mid-bit.
  task automatic send_byte(input logic which, input logic [7:0] b, input logic stop, input int rst_at_bit);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(which, fr[i]);
      if (i == rst_at_bit) begin
        repeat (CLKS / 2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("midrst");
        drive(which, 1'b1);
        repeat (3 * CLKS) tick();
        return;
      end
      repeat (CLKS) tick();
    end
    drive(which, 1'b1);
  endtask

  task automatic send_word(input logic which, input logic [7:0] hi, input logic [7:0] lo);
    send_byte(which, hi, 1'b1, -1);
    send_byte(which, lo, 1'b1, -1);
    repeat (2) tick();
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < TMO_CYC + 200) begin
      tick();
      k++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int k;
    int lat_ok;
    wr_t e;
    logic [7:0] hi, lo;

    // 1: single word, done latency
    do_reset();
    e.addr = 8'd1; e.data = 16'h4100; exp_q.push_back(e);
    send_byte(1'b0, 8'h41, 1'b1, -1);
    send_byte(1'b0, 8'h00, 1'b1, -1);
    wait_done(k);
    lat_ok = (k >= TMO_CYC - LAG - 2 && k <= TMO_CYC - LAG + 2) ? 1 : 0;
    if (lat_ok == 0) $display("done latency %0d cycles after frame end, nominal %0d", k, TMO_CYC - LAG);
    check("done_latency_window", lat_ok, 1);
    check("t1_maxa", {24'd0, maxa}, 32'd1);
    check("t1_pending", exp_q.size(), 0);

    // 2: fifteen words, then traffic after done is ignored
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      hi = (i == 15) ? 8'hE0 : 8'(i);
      lo = (i == 15) ? 8'h00 : ~8'(i);
      e.addr = 8'(i); e.data = {hi, lo}; exp_q.push_back(e);
      send_word(1'b0, hi, lo);
    end
    check("t2_pending", exp_q.size(), 0);
    wait_done(k);
    check("t2_maxa", {24'd0, maxa}, 32'd15);
    send_word(1'b0, 8'hAB, 8'hCD);
    repeat (CLKS) tick();
    check("t2_maxa_after", {24'd0, maxa}, 32'd15);
    check("t2_done_hold", {31'd0, done}, 32'd1);

    // 3: short glitch produces nothing
    do_reset();
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (3 * CLKS) tick();
    check("t3_ferr", {31'd0, ferr}, 32'd0);
    check("t3_maxa", {24'd0, maxa}, 32'd0);
    e.addr = 8'd1; e.data = 16'h1234; exp_q.push_back(e);
    send_word(1'b0, 8'h12, 8'h34);
    check("t3_pending", exp_q.size(), 0);
    check("t3_maxa2", {24'd0, maxa}, 32'd1);

    // 4: framing error discards the byte
    do_reset();
    send_byte(1'b0, 8'hAA, 1'b0, -1);
    repeat (2 * CLKS) tick();
    check("t4_ferr", {31'd0, ferr}, 32'd1);
    check("t4_maxa0", {24'd0, maxa}, 32'd0);
    e.addr = 8'd1; e.data = 16'h5566; exp_q.push_back(e);
    send_word(1'b0, 8'h55, 8'h66);
    check("t4_pending", exp_q.size(), 0);
    check("t4_ferr_hold", {31'd0, ferr}, 32'd1);
    check("t4_maxa", {24'd0, maxa}, 32'd1);

    // 5: overflow on 2-bit address space
    do_reset();
    for (int w = 0; w < 4; w++) begin
      if (w < 3) begin
        e.addr = 8'(w + 1); e.data = 16'hA000 + 16'(w); exp2_q.push_back(e);
      end
      if (w == 3) begin
        check("t5_ovf_before", {31'd0, ovf2}, 32'd0);
        check("t5_maxa_before", {30'd0, maxa2}, 32'd3);
      end
      send_word(1'b1, 8'hA0, 8'(w));
    end
    check("t5_ovf", {31'd0, ovf2}, 32'd1);
    check("t5_maxa", {30'd0, maxa2}, 32'd3);
    check("t5_pending", exp2_q.size(), 0);

    // 6: reset during data bits of the second byte
    do_reset();
    send_byte(1'b0, 8'h77, 1'b1, -1);
    send_byte(1'b0, 8'h88, 1'b1, 4);
    e.addr = 8'd1; e.data = 16'h0FF0; exp_q.push_back(e);
    send_word(1'b0, 8'h0F, 8'hF0);
    check("t6_pending", exp_q.size(), 0);
    check("t6_maxa", {24'd0, maxa}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_instr_loader.md
Name: uart_instr_loader

Overview:
Upstream program-load stage for TOP_CPU. It receives the serial instruction stream on the UART RX line (8N1, LSB first) and pairs consecutive bytes into 16-bit instruction words. Each word is written into instruction memory, starting at address 1. After the stream goes idle it reports the last written address and asserts the transmit-done flag that gates CPU start.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud).
ADDR_W, 8, instruction memory address width.
START_ADDR, 1, address of the first written word.
IDLE_TIMEOUT_BITS, 20, idle bit-periods after the last word before done is declared.

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst  input  1  synchronous active-high reset
i_rx  input  1  asynchronous UART RX line, idle high
o_mem_we  output  1  one-cycle instruction-memory write strobe
o_mem_addr  output  ADDR_W  write address, valid when o_mem_we=1
o_mem_wdata  output  16  instruction word, valid when o_mem_we=1
o_instr_transmit_done  output  1  sticky: program load complete
o_max_addr  output  ADDR_W  address of last word written
o_frame_err  output  1  sticky: a stop bit sampled low
o_overflow  output  1  sticky: word dropped because memory was full

Behaviour:
- Reset (i_rst=1 at a clock edge): all outputs 0. Write pointer = START_ADDR. Byte pairing cleared. RX FSM = IDLE. Synchronizer flops = 1. Reset mid-byte abandons the byte with no write.
- Input sync: 2-flop synchronizer on i_rx. All RX logic uses the synchronized signal.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronized rx = 0; clear the bit counter.
  - START: at count CLKS_PER_BIT/2 (integer division), sample rx. If 1 (glitch), go to IDLE with no byte. If 0, go to DATA and reset the counter.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit). Shift LSB first. After 8 samples, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx. If 1, the byte is valid (one-cycle internal strobe). If 0, discard the byte, set o_frame_err, and clear byte pairing. Then go to IDLE; IDLE does not require a full stop period before the next start bit.
- Byte pairing: the first valid byte goes to word[15:8], the second to word[7:0].
- Write: on the cycle after the second byte's valid strobe, drive o_mem_we=1 for exactly one cycle, with o_mem_addr = pointer and o_mem_wdata = word. On the same edge, update o_max_addr to pointer and increment the pointer.
- Full memory: once a word has been written at address 2^ADDR_W-1, the pointer does not wrap. Later completed words produce no o_mem_we; o_overflow is set, and o_max_addr holds at 2^ADDR_W-1.
- Idle timer:
  - Counts while the RX FSM is in IDLE and at least one word has been written.
  - Clears on any start-bit detection.
  - On reaching IDLE_TIMEOUT_BITS*CLKS_PER_BIT, set o_instr_transmit_done (sticky until reset).
  - A pending half-word at timeout is discarded silently.
  - With zero words written, done never asserts.
- After done: RX input is ignored, no further writes occur, and all flags hold.
- Simultaneous events: a valid-byte strobe and timer expiry cannot coincide, because the timer is cleared on start detection. A framing error on the second byte of a pair means no write.

Test Plan:
1. Reset, then send bytes 0x41, 0x00 at CLKS_PER_BIT=868 -> single o_mem_we pulse with addr=1, wdata=0x4100. o_max_addr=1. o_instr_transmit_done rises 20*868 cycles after the stop-bit sample of the last byte, ±2 cycles.
2. Send 30 bytes forming 15 words; the last pair is 0xE0, 0x00 -> 15 writes at addrs 1..15, last wdata=0xE000. o_max_addr=15. Done asserted. Bytes sent after done produce no writes.
3. Glitch: drive i_rx low for 300 cycles (< 434), then high -> no byte, no write, o_frame_err=0. Next pair 0x12, 0x34 writes 0x1234 at addr 1.
4. Framing error: send 0xAA with stop bit held low, then pair 0x55, 0x66 -> o_frame_err=1, no write for 0xAA, and 0x5566 written at addr 1.
5. Overflow with ADDR_W=2: send 4 words -> writes at addrs 1, 2, 3; 4th word dropped with o_overflow=1 and o_max_addr=3.
6. Assert i_rst for one cycle during DATA of the second byte of a pair -> no write. All outputs 0 on the next cycle. The subsequent pair 0x0F, 0xF0 writes 0x0FF0 at addr 1.
